// File: rtl/subchannel_dispatcher.sv
// Slices or broadcasts wide host beats into per-subchannel FWFT FIFOs with
// backpressure, flush, fill-level reporting and no-target drop accounting.
module subchannel_dispatcher #(
  parameter int NUM_SUBCHANNELS = 2,
  parameter int SUBCH_WIDTH     = 40,
  parameter int FIFO_DEPTH      = 8,
  parameter int DATA_WIDTH      = NUM_SUBCHANNELS * SUBCH_WIDTH
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [NUM_SUBCHANNELS-1:0]                            cfg_subch_en,
  input  logic                                                  cfg_gang_mode,
  input  logic                                                  cfg_flush,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                                 in_data,
  output logic [NUM_SUBCHANNELS-1:0]                            out_valid,
  input  logic [NUM_SUBCHANNELS-1:0]                            out_ready,
  output logic [NUM_SUBCHANNELS*SUBCH_WIDTH-1:0]                out_data,
  output logic [NUM_SUBCHANNELS*($clog2(FIFO_DEPTH)+1)-1:0]     fifo_level,
  output logic                                                  err_no_target,
  input  logic                                                  err_clr,
  output logic [15:0]                                           drop_cnt
);

  localparam int N  = NUM_SUBCHANNELS;
  localparam int W  = SUBCH_WIDTH;
  localparam int D  = FIFO_DEPTH;
  localparam int AW = $clog2(D);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(D);

  logic [W-1:0]  mem_q    [N][D];
  logic [W-1:0]  mem_d    [N][D];
  logic [AW-1:0] wr_ptr_q [N];
  logic [AW-1:0] wr_ptr_d [N];
  logic [AW-1:0] rd_ptr_q [N];
  logic [AW-1:0] rd_ptr_d [N];
  logic [LW-1:0] level_q  [N];
  logic [LW-1:0] level_d  [N];
  logic          err_q, err_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic [N-1:0]  full;
  logic [N-1:0]  push;
  logic [N-1:0]  pop;
  logic          any_target;
  logic          accept;
  logic          drop;

  // in_ready looks only at registered levels, so a same-cycle pop never frees a slot
  always_comb begin
    full = '0;
    pop  = '0;
    for (int i = 0; i < N; i++) begin
      full[i] = (level_q[i] == LVL_FULL);
      pop[i]  = (level_q[i] != '0) & out_ready[i];
    end
    any_target = |cfg_subch_en;
    in_ready   = ~|(cfg_subch_en & full);
    accept     = in_valid & in_ready & any_target;
    drop       = in_valid & in_ready & ~any_target;
    push       = {N{accept}} & cfg_subch_en;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    err_d      = err_q;
    drop_cnt_d = drop_cnt_q;

    for (int i = 0; i < N; i++) begin
      if (cfg_flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        level_d[i]  = '0;
      end else begin
        if (push[i]) begin
          mem_d[i][wr_ptr_q[i]] = cfg_gang_mode ? in_data[W-1:0] : in_data[i*W +: W];
          wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
        end
        if (pop[i]) begin
          rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
        end
        if (push[i] && !pop[i]) begin
          level_d[i] = level_q[i] + LW'(1);
        end else if (!push[i] && pop[i]) begin
          level_d[i] = level_q[i] - LW'(1);
        end
      end
    end

    // a drop in the same cycle as err_clr keeps the error set
    if (drop) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < D; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        level_q[i]  <= '0;
      end
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    out_valid  = '0;
    out_data   = '0;
    fifo_level = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i]             = (level_q[i] != '0);
      out_data[i*W +: W]       = (level_q[i] != '0) ? mem_q[i][rd_ptr_q[i]] : '0;
      fifo_level[i*LW +: LW]   = level_q[i];
    end
    err_no_target = err_q;
    drop_cnt      = drop_cnt_q;
  end

endmodule

// File: tb/tb_subchannel_dispatcher.sv
// Bench for subchannel_dispatcher: constant vector table, directed corner
// sequences and a random phase, all checked against a queue-based model.
module tb_subchannel_dispatcher;

  localparam int N = 2;
  localparam int W = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  cfg_subch_en;
  logic          cfg_gang_mode;
  logic          cfg_flush;
  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [N*W-1:0] out_data;
  logic [7:0]    fifo_level;
  logic          err_no_target;
  logic          err_clr;
  logic [15:0]   drop_cnt;

  subchannel_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .cfg_subch_en(cfg_subch_en), .cfg_gang_mode(cfg_gang_mode),
    .cfg_flush(cfg_flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_level(fifo_level), .err_no_target(err_no_target), .err_clr(err_clr),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq [N][$];
  logic         m_err;
  logic [15:0]  m_drop;

  typedef struct {
    logic [1:0]  en;
    logic        gang;
    logic        flush;
    logic        valid;
    logic        clr;
    logic [1:0]  ordy;
    logic [39:0] d0;
    logic [39:0] d1;
    logic        exp_ready;
    logic [3:0]  exp_l0;
    logic [3:0]  exp_l1;
    logic [39:0] exp_o0;
    logic [39:0] exp_o1;
    logic        exp_err;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic model_ready();
    logic r = 1'b1;
    for (int i = 0; i < N; i++)
      if (cfg_subch_en[i] && mq[i].size() >= 8) r = 1'b0;
    return r;
  endfunction

  task automatic chk_model();
    chk("m_in_ready", 64'(in_ready), 64'(model_ready()));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("m_out_valid%0d", i), 64'(out_valid[i]), 64'(mq[i].size() != 0));
      chk($sformatf("m_out_data%0d", i), 64'(out_data[i*W +: W]),
          (mq[i].size() != 0) ? 64'(mq[i][0]) : 64'd0);
      chk($sformatf("m_level%0d", i), 64'(fifo_level[i*4 +: 4]), 64'(mq[i].size()));
    end
    chk("m_err", 64'(err_no_target), 64'(m_err));
    chk("m_drop", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_err  = 1'b0;
    m_drop = '0;
  endtask

  // one clock: check against model, take the edge, advance the model
  task automatic step();
    logic er;
    #1;
    chk_model();
    er = model_ready();
    @(posedge clk);
    if (cfg_flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
        if (in_valid && er && cfg_subch_en[i])
          mq[i].push_back(cfg_gang_mode ? in_data[W-1:0] : in_data[i*W +: W]);
      end
    end
    if (in_valid && er && cfg_subch_en == '0) begin
      m_err = 1'b1;
      if (m_drop != 16'hFFFF) m_drop++;
    end else if (err_clr) begin
      m_err = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic [1:0] en, input logic gang, input logic valid,
                       input logic [39:0] d0, input logic [39:0] d1, input logic [1:0] ordy,
                       input logic flush, input logic clr);
    cfg_subch_en  = en;
    cfg_gang_mode = gang;
    in_valid      = valid;
    in_data       = {d1, d0};
    out_ready     = ordy;
    cfg_flush     = flush;
    err_clr       = clr;
  endtask

  task automatic set_vec(input int k, input logic [1:0] en, input logic gang, input logic flush,
                         input logic valid, input logic clr, input logic [1:0] ordy,
                         input logic [39:0] d0, input logic [39:0] d1, input logic er,
                         input logic [3:0] l0, input logic [3:0] l1, input logic [39:0] o0,
                         input logic [39:0] o1, input logic err, input logic [15:0] drp);
    vt[k].en = en; vt[k].gang = gang; vt[k].flush = flush; vt[k].valid = valid;
    vt[k].clr = clr; vt[k].ordy = ordy; vt[k].d0 = d0; vt[k].d1 = d1;
    vt[k].exp_ready = er; vt[k].exp_l0 = l0; vt[k].exp_l1 = l1;
    vt[k].exp_o0 = o0; vt[k].exp_o1 = o1; vt[k].exp_err = err; vt[k].exp_drop = drp;
  endtask

  initial begin
    logic [95:0]  rnd;
    logic [15:0]  saved_drop;
    logic [1:0]   ordy;

    //        k en    g  fl v  clr ordy   d0             d1      rdy l0 l1 o0             o1             err drop
    set_vec(0, 2'b00, 0, 0, 1, 0, 2'b00, 40'h1,        40'h2,  1, 0, 0, 40'h0,        40'h0,        1, 16'd1);
    set_vec(1, 2'b00, 0, 0, 1, 0, 2'b00, 40'h3,        40'h4,  1, 0, 0, 40'h0,        40'h0,        1, 16'd2);
    set_vec(2, 2'b00, 0, 0, 1, 0, 2'b00, 40'h5,        40'h6,  1, 0, 0, 40'h0,        40'h0,        1, 16'd3);
    set_vec(3, 2'b00, 0, 0, 1, 1, 2'b00, 40'h7,        40'h8,  1, 0, 0, 40'h0,        40'h0,        1, 16'd4);
    set_vec(4, 2'b00, 0, 0, 0, 1, 2'b00, 40'h0,        40'h0,  1, 0, 0, 40'h0,        40'h0,        0, 16'd4);
    set_vec(5, 2'b11, 1, 0, 1, 0, 2'b00, 40'hAABBCCDDEE, 40'h0, 1, 1, 1, 40'hAABBCCDDEE, 40'hAABBCCDDEE, 0, 16'd4);
    set_vec(6, 2'b11, 0, 0, 0, 0, 2'b11, 40'h0,        40'h0,  1, 0, 0, 40'h0,        40'h0,        0, 16'd4);
    set_vec(7, 2'b01, 0, 0, 1, 0, 2'b00, 40'h5,        40'h7,  1, 1, 0, 40'h5,        40'h0,        0, 16'd4);
    set_vec(8, 2'b10, 0, 0, 1, 0, 2'b01, 40'h1,        40'h9,  1, 0, 1, 40'h0,        40'h9,        0, 16'd4);
    set_vec(9, 2'b00, 0, 1, 0, 0, 2'b00, 40'h0,        40'h0,  1, 0, 0, 40'h0,        40'h0,        0, 16'd4);

    rst_n = 1'b0;
    drive(2'b00, 0, 0, 40'h0, 40'h0, 2'b00, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data[63:0]), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_err", 64'(err_no_target), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // constant vector table
    for (int k = 0; k < 10; k++) begin
      drive(vt[k].en, vt[k].gang, vt[k].valid, vt[k].d0, vt[k].d1, vt[k].ordy,
            vt[k].flush, vt[k].clr);
      #1;
      chk($sformatf("v%0d_ready", k), 64'(in_ready), 64'(vt[k].exp_ready));
      step();
      chk($sformatf("v%0d_l0", k), 64'(fifo_level[3:0]), 64'(vt[k].exp_l0));
      chk($sformatf("v%0d_l1", k), 64'(fifo_level[7:4]), 64'(vt[k].exp_l1));
      chk($sformatf("v%0d_o0", k), 64'(out_data[39:0]), 64'(vt[k].exp_o0));
      chk($sformatf("v%0d_o1", k), 64'(out_data[79:40]), 64'(vt[k].exp_o1));
      chk($sformatf("v%0d_err", k), 64'(err_no_target), 64'(vt[k].exp_err));
      chk($sformatf("v%0d_drop", k), 64'(drop_cnt), 64'(vt[k].exp_drop));
    end

    // split fill then ordered drain
    for (int b = 0; b < 8; b++) begin
      drive(2'b11, 0, 1, 40'(b), 40'(32'h100 + b), 2'b00, 0, 0);
      step();
    end
    chk("fill_l0", 64'(fifo_level[3:0]), 64'd8);
    chk("fill_l1", 64'(fifo_level[7:4]), 64'd8);
    drive(2'b11, 0, 1, 40'h99, 40'h99, 2'b00, 0, 0);
    #1;
    chk("fill_ready", 64'(in_ready), 64'd0);
    step();
    for (int b = 0; b < 8; b++) begin
      drive(2'b11, 0, 0, 40'h0, 40'h0, 2'b11, 0, 0);
      chk($sformatf("drain_o0_%0d", b), 64'(out_data[39:0]), 64'(b));
      chk($sformatf("drain_o1_%0d", b), 64'(out_data[79:40]), 64'(32'h100 + b));
      step();
    end
    chk("drain_level", 64'(fifo_level), 64'd0);

    // partial enable and backpressure
    for (int b = 0; b < 3; b++) begin
      drive(2'b10, 0, 1, 40'h0, 40'(32'h500 + b), 2'b00, 0, 0);
      step();
    end
    for (int b = 0; b < 8; b++) begin
      drive(2'b01, 0, 1, 40'(32'h600 + b), 40'hDEAD, 2'b00, 0, 0);
      step();
    end
    drive(2'b01, 0, 1, 40'h77, 40'h77, 2'b00, 0, 0);
    #1;
    chk("part_ready0", 64'(in_ready), 64'd0);
    chk("part_l0", 64'(fifo_level[3:0]), 64'd8);
    chk("part_l1", 64'(fifo_level[7:4]), 64'd3);
    step();
    for (int b = 0; b < 5; b++) begin
      drive(2'b10, 0, 1, 40'h0, 40'(32'h700 + b), 2'b00, 0, 0);
      step();
    end
    chk("part_l1_full", 64'(fifo_level[7:4]), 64'd8);
    drive(2'b10, 0, 1, 40'h0, 40'h88, 2'b00, 0, 0);
    #1;
    chk("part_ready1", 64'(in_ready), 64'd0);
    step();
    for (int b = 0; b < 8; b++) begin
      drive(2'b00, 0, 0, 40'h0, 40'h0, 2'b11, 0, 0);
      step();
    end

    // full FIFO with a pop: no pass-through, then wrap with continuous traffic
    for (int b = 0; b < 8; b++) begin
      drive(2'b01, 0, 1, 40'(32'h200 + b), 40'h0, 2'b00, 0, 0);
      step();
    end
    drive(2'b01, 0, 1, 40'h300, 40'h0, 2'b01, 0, 0);
    #1;
    chk("fullpop_ready", 64'(in_ready), 64'd0);
    step();
    chk("fullpop_l0", 64'(fifo_level[3:0]), 64'd7);
    for (int b = 0; b < 20; b++) begin
      drive(2'b01, 0, 1, 40'(32'h300 + b), 40'h0, 2'b01, 0, 0);
      step();
    end
    chk("wrap_l0", 64'(fifo_level[3:0]), 64'd7);
    for (int b = 0; b < 8; b++) begin
      drive(2'b00, 0, 0, 40'h0, 40'h0, 2'b01, 0, 0);
      step();
    end

    // flush with a same-cycle push and pop
    for (int b = 0; b < 5; b++) begin
      drive(2'b11, 0, 1, 40'(32'h400 + b), 40'(32'h480 + b), 2'b00, 0, 0);
      step();
    end
    chk("pre_flush_l", 64'(fifo_level), 64'h55);
    saved_drop = drop_cnt;
    drive(2'b11, 0, 1, 40'h4FF, 40'h4FF, 2'b11, 1, 0);
    step();
    chk("flush_level", 64'(fifo_level), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'(saved_drop));

    // asynchronous reset between edges
    for (int b = 0; b < 3; b++) begin
      drive(2'b11, 0, 1, 40'(32'h900 + b), 40'(32'h980 + b), 2'b00, 0, 0);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_drop", 64'(drop_cnt), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    model_reset();
    drive(2'b00, 0, 0, 40'h0, 40'h0, 2'b00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rnd  = {$urandom, $urandom, $urandom};
      ordy = {($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 4)};
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
            rnd[39:0], rnd[79:40], ordy, ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/subchannel_dispatcher.md
Name: subchannel_dispatcher

Overview:
Parametrised successor to the fixed two-subchannel controller. It accepts wide host beats over a valid/ready handshake and slices or replicates them into N independent per-subchannel FIFOs, each with its own valid/ready output. It adds backpressure, a gang (broadcast) mode, flush, fill-level reporting, and error/drop accounting. It sits between the host-side signal router and the per-subchannel DRAM drivers.

Parameters:
NUM_SUBCHANNELS, 2, number of subchannels N (1..8)
SUBCH_WIDTH, 40, bits per subchannel beat W
FIFO_DEPTH, 8, entries per subchannel FIFO D (power of 2, >=2)
DATA_WIDTH, NUM_SUBCHANNELS*SUBCH_WIDTH, host beat width (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_subch_en  in  N  per-subchannel enable
cfg_gang_mode  in  1  0 = split, 1 = broadcast slice 0
cfg_flush  in  1  single-cycle pulse: empty all FIFOs
in_valid  in  1  host beat valid
in_ready  out  1  host beat ready
in_data  in  DATA_WIDTH  host beat; slice i = bits [i*W +: W]
out_valid  out  N  subchannel i head valid
out_ready  in  N  subchannel i consumer ready
out_data  out  N*W  subchannel i head data at [i*W +: W]
fifo_level  out  N*($clog2(D)+1)  occupancy of FIFO i, 0..D
err_no_target  out  1  sticky: a beat arrived with no subchannel enabled
err_clr  in  1  clears err_no_target
drop_cnt  out  16  count of dropped beats, saturating

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All FIFOs empty; fifo_level=0; out_valid=0; out_data=0.
  - err_no_target=0; drop_cnt=0.
- Target set:
  - T = cfg_subch_en, sampled the same cycle as the handshake.
- in_ready (combinational from registered state and cfg):
  - If T==0: in_ready=1. The beat is consumed so the host never deadlocks.
  - Else: in_ready=1 only when every FIFO i in T has level < D.
  - A pop in the same cycle does not free a slot for a push: no full pass-through.
- Accept = in_valid & in_ready & (T!=0):
  - Split mode: slice i is pushed into FIFO i for each i in T.
  - Gang mode: slice 0 is pushed into every FIFO i in T.
  - FIFOs not in T are untouched.
- Drop = in_valid & in_ready & (T==0):
  - err_no_target=1 on the next edge.
  - drop_cnt increments by 1 and saturates at 16'hFFFF.
  - Drop and err_clr in the same cycle: set wins.
- Output side, per FIFO i, first-word-fall-through:
  - out_valid[i] = level_i != 0.
  - out_data slice i = head entry when valid, 0 when empty.
  - Pop when out_valid[i] & out_ready[i].
  - Disabling a subchannel does not stop its drain. Popping continues until empty.
- Latency: a beat accepted at edge k appears at out_valid/out_data after edge k (one cycle).
- Simultaneous push and pop on FIFO i: level unchanged; data order preserved.
- Pointers are log2(D) bits and wrap modulo D. Level is tracked separately, so full and empty are distinguished.
- fifo_level reflects the registered count after each edge.
- cfg_flush:
  - At the next edge all pointers and levels go to 0 and out_valid goes to 0.
  - Flush dominates any same-cycle push or pop; that beat is lost.
  - Flush does not touch err_no_target or drop_cnt.
  - in_ready in the flush cycle follows the normal rule.
- Mid-operation reset: immediate return to reset values. No partial beats survive.
- cfg changes take effect on the same cycle's in_ready and accept. No pipeline of cfg is required.

Test Plan:
- Split fill:
  - Stimulus: N=2, en=2'b11, gang=0, out_ready=0, push 8 beats with slice0=i, slice1=0x100+i.
  - Required: levels 8/8, in_ready=0 after 8th accept; drain with out_ready=2'b11 gives 0..7 and 0x100..0x107 in order, levels return to 0.
- Gang broadcast:
  - Stimulus: en=2'b11, gang=1, in_data slice0=40'hAA_BBCC_DDEE, slice1=0.
  - Required: both outputs show 40'hAA_BBCC_DDEE one cycle later.
- Partial enable and backpressure:
  - Stimulus: en=2'b01, FIFO1 pre-loaded with 3 entries, out_ready=2'b00, push 8 beats.
  - Required: FIFO0 level 8, in_ready=0; FIFO1 level stays 3; en=2'b10 then lets FIFO1 accept until level 8.
- No-target drop:
  - Stimulus: en=0, in_valid=1 for 3 cycles.
  - Required: in_ready=1 throughout, err_no_target=1, drop_cnt=3, all levels 0. err_clr with a 4th drop in the same cycle leaves err=1 and drop_cnt=4. err_clr alone then clears err.
- Full with pop and wrap:
  - Stimulus: FIFO0 full, out_ready[0]=1 with in_valid=1.
  - Required: in_ready=0 that cycle, level goes to 7, accept on the next cycle. After 20 continuous push/pop beats, data order is intact across pointer wrap.
- Flush and reset mid-stream:
  - Stimulus: cfg_flush with a push and a pop in the same cycle at levels 5/5.
  - Required: levels 0/0, out_valid=0, drop_cnt unchanged. Asserting rst_n=0 between edges forces out_valid=0 and drop_cnt=0 immediately.
